// File: rtl/nird_joint_histogram_if.sv
// rtl/nird_joint_histogram_if.sv - code input and histogram readout bundle for nird_joint_histogram
interface nird_joint_histogram_if #(
  parameter int CNT_W = 10
);
  logic [3:0]       ni_i;
  logic [3:0]       rd_i;
  logic             done_i;
  logic             progress_done_i;
  logic [CNT_W-1:0] hist_o;
  logic [7:0]       bin_idx_o;
  logic             hist_valid_o;
  logic             hist_ready_i;
  logic             frame_done_o;
  logic [CNT_W-1:0] pix_cnt_o;
  logic             err_o;

  // Producer of codes and consumer of the readout stream
  modport master (
    output ni_i, rd_i, done_i, progress_done_i, hist_ready_i,
    input  hist_o, bin_idx_o, hist_valid_o, frame_done_o, pix_cnt_o, err_o
  );

  // The histogram block itself
  modport slave (
    input  ni_i, rd_i, done_i, progress_done_i, hist_ready_i,
    output hist_o, bin_idx_o, hist_valid_o, frame_done_o, pix_cnt_o, err_o
  );
endinterface

// File: rtl/nird_joint_histogram.sv
// rtl/nird_joint_histogram.sv - joint NI x RD histogram per frame with streamed readout (optional marginals: NIRD_HIST_MARGINAL_EN)
module nird_joint_histogram #(
  parameter int COLS  = 30,
  parameter int ROWS  = 30,
  parameter int BINS  = 10,
  parameter int CNT_W = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  nird_joint_histogram_if.slave  bus
);

  localparam int NJ = BINS * BINS;
`ifdef NIRD_HIST_MARGINAL_EN
  localparam int NOUT = NJ + 2 * BINS;
`else
  localparam int NOUT = NJ;
`endif
  localparam logic [7:0]       LAST_IDX = 8'(NOUT - 1);
  localparam logic [7:0]       BINS_B   = 8'(BINS);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // A frame larger than the counter range simply saturates the counters.
  if (COLS * ROWS > (2 ** CNT_W) - 1) begin : g_frame_exceeds_counter
  end

  typedef enum logic [1:0] {
    ST_ACCUM,
    ST_READOUT,
    ST_DONE,
    ST_CLEAR
  } state_t;

  state_t           state;
  logic [7:0]       idx;
  logic [CNT_W-1:0] pix_cnt;
  logic             hist_valid;
  logic             frame_done;
  logic             err;
  logic [CNT_W-1:0] joint [NJ];
  logic [CNT_W-1:0] hist_rd;

  logic             code_ok;
  logic             take;
  logic             accept;
  logic [7:0]       wr_addr;

  assign code_ok = ({4'd0, bus.ni_i} < BINS_B) && ({4'd0, bus.rd_i} < BINS_B);
  assign take    = bus.done_i && code_ok && (state == ST_ACCUM);
  assign accept  = hist_valid && bus.hist_ready_i;
  assign wr_addr = {4'd0, bus.ni_i} * BINS_B + {4'd0, bus.rd_i};

  // Frame sequencing: accumulate, drain, pulse done, clear; error flag is sticky
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_ACCUM;
      idx        <= 8'd0;
      pix_cnt    <= '0;
      hist_valid <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_ACCUM: begin
          if (bus.done_i && !code_ok) err <= 1'b1;
          if (take && pix_cnt != CNT_MAX) pix_cnt <= pix_cnt + CNT_ONE;
          if (bus.progress_done_i) begin
            state      <= ST_READOUT;
            hist_valid <= 1'b1;
          end
        end
        ST_READOUT: begin
          if (bus.done_i) err <= 1'b1;
          if (accept) begin
            if (idx == LAST_IDX) begin
              state      <= ST_DONE;
              hist_valid <= 1'b0;
              frame_done <= 1'b1;
            end else begin
              idx <= idx + 8'd1;
            end
          end
        end
        ST_DONE: begin
          if (bus.done_i) err <= 1'b1;
          state <= ST_CLEAR;
        end
        ST_CLEAR: begin
          if (bus.done_i) err <= 1'b1;
          idx     <= 8'd0;
          pix_cnt <= '0;
          state   <= ST_ACCUM;
        end
        default: state <= ST_ACCUM;
      endcase
    end
  end

  // Joint bin counters: saturating increment on accepted samples, zeroed in CLEAR
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NJ; k++) joint[k] <= '0;
    end else if (state == ST_CLEAR) begin
      for (int k = 0; k < NJ; k++) joint[k] <= '0;
    end else if (take) begin
      for (int k = 0; k < NJ; k++) begin
        if (wr_addr == 8'(k) && joint[k] != CNT_MAX) joint[k] <= joint[k] + CNT_ONE;
      end
    end
  end

`ifdef NIRD_HIST_MARGINAL_EN
  logic [CNT_W-1:0] ni_marg [BINS];
  logic [CNT_W-1:0] rd_marg [BINS];

  // Marginal counters track the same accepted samples as the joint bins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < BINS; k++) begin
        ni_marg[k] <= '0;
        rd_marg[k] <= '0;
      end
    end else if (state == ST_CLEAR) begin
      for (int k = 0; k < BINS; k++) begin
        ni_marg[k] <= '0;
        rd_marg[k] <= '0;
      end
    end else if (take) begin
      for (int k = 0; k < BINS; k++) begin
        if (bus.ni_i == 4'(k) && ni_marg[k] != CNT_MAX) ni_marg[k] <= ni_marg[k] + CNT_ONE;
        if (bus.rd_i == 4'(k) && rd_marg[k] != CNT_MAX) rd_marg[k] <= rd_marg[k] + CNT_ONE;
      end
    end
  end

  // Read mux: joint bins first, then NI marginals, then RD marginals
  always_comb begin
    hist_rd = '0;
    for (int k = 0; k < NJ; k++) begin
      if (idx == 8'(k)) hist_rd = joint[k];
    end
    for (int k = 0; k < BINS; k++) begin
      if (idx == 8'(NJ + k)) hist_rd = ni_marg[k];
      if (idx == 8'(NJ + BINS + k)) hist_rd = rd_marg[k];
    end
  end
`else
  // Read mux over the joint bins only
  always_comb begin
    hist_rd = '0;
    for (int k = 0; k < NJ; k++) begin
      if (idx == 8'(k)) hist_rd = joint[k];
    end
  end
`endif

  assign bus.hist_o       = hist_rd;
  assign bus.bin_idx_o    = idx;
  assign bus.hist_valid_o = hist_valid;
  assign bus.frame_done_o = frame_done;
  assign bus.pix_cnt_o    = pix_cnt;
  assign bus.err_o        = err;

endmodule

// File: tb/tb_nird_joint_histogram.sv
// tb/tb_nird_joint_histogram.sv - scoreboard bench for nird_joint_histogram
module tb_nird_joint_histogram;

  localparam int BINS  = 10;
  localparam int CNT_W = 10;
  localparam int NJ    = BINS * BINS;
`ifdef NIRD_HIST_MARGINAL_EN
  localparam int LEN = NJ + 2 * BINS;
`else
  localparam int LEN = NJ;
`endif
  localparam int MAXC = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  nird_joint_histogram_if #(.CNT_W(CNT_W)) bus ();

  nird_joint_histogram #(
    .COLS(30), .ROWS(30), .BINS(BINS), .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_pass  = 0;
  int n_total = 0;

  int exp_idx[$];
  int exp_val[$];
  int rd_ptr      = 0;
  int frames_done = 0;
  int beats       = 0;
  bit fd_pending  = 0;
  bit hold_v      = 0;
  int hold_idx    = 0;
  int hold_val    = 0;
  int rmode       = 0;

  int ref_bins [LEN];
  int ref_pix;
  int frames_target;

  function automatic void chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endfunction

  function automatic int sat_inc(input int v);
    return (v >= MAXC) ? MAXC : v + 1;
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < LEN; i++) ref_bins[i] = 0;
    ref_pix = 0;
  endfunction

  function automatic void model_add(input int ni, input int rd);
    if (ni < BINS && rd < BINS) begin
      ref_bins[ni * BINS + rd] = sat_inc(ref_bins[ni * BINS + rd]);
`ifdef NIRD_HIST_MARGINAL_EN
      ref_bins[NJ + ni]        = sat_inc(ref_bins[NJ + ni]);
      ref_bins[NJ + BINS + rd] = sat_inc(ref_bins[NJ + BINS + rd]);
`endif
      ref_pix = sat_inc(ref_pix);
    end
  endfunction

  // Readout ready pattern: 0 = always ready, 1 = 1,0,0 repeating, 2 = random
  initial begin
    int ph;
    ph = 0;
    bus.hist_ready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        1:       begin bus.hist_ready_i = (ph % 3 == 0); ph++; end
        2:       bus.hist_ready_i = 1'($urandom_range(0, 1));
        default: bus.hist_ready_i = 1'b1;
      endcase
    end
  end

  // Monitor: pops expected beats on each accepted transfer, checks stability and frame_done
  always @(negedge clk) begin
    if (rst) begin
      rd_ptr     = exp_idx.size();
      hold_v     = 0;
      fd_pending = 0;
      beats      = 0;
    end else begin
      if (fd_pending) begin
        chk("frame_done_after_last", int'(bus.frame_done_o), 1);
        chk("beat_count", beats, LEN);
        fd_pending = 0;
        beats      = 0;
        frames_done++;
      end else if (bus.frame_done_o) begin
        chk("frame_done_spurious", 1, 0);
      end
      if (hold_v && bus.hist_valid_o) begin
        chk("stall_idx_stable", int'(bus.bin_idx_o), hold_idx);
        chk("stall_val_stable", int'(bus.hist_o), hold_val);
      end
      hold_v   = bus.hist_valid_o && !bus.hist_ready_i;
      hold_idx = int'(bus.bin_idx_o);
      hold_val = int'(bus.hist_o);
      if (bus.hist_valid_o && bus.hist_ready_i) begin
        if (rd_ptr >= exp_idx.size()) begin
          chk("unexpected_beat", int'(bus.bin_idx_o), -1);
        end else begin
          chk("beat_idx", int'(bus.bin_idx_o), exp_idx[rd_ptr]);
          chk($sformatf("bin_val_%0d", exp_idx[rd_ptr]), int'(bus.hist_o), exp_val[rd_ptr]);
          rd_ptr++;
          beats++;
          if (rd_ptr == exp_idx.size()) fd_pending = 1;
        end
      end
    end
  end

  task automatic sample(input int ni, input int rd, input bit track);
    bus.ni_i   = 4'(ni);
    bus.rd_i   = 4'(rd);
    bus.done_i = 1'b1;
    if (track) model_add(ni, rd);
    @(posedge clk);
    #1;
    bus.done_i = 1'b0;
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
  endtask

  task automatic end_frame(input bit with_done, input int ni, input int rd);
    if (with_done) begin
      model_add(ni, rd);
      bus.ni_i   = 4'(ni);
      bus.rd_i   = 4'(rd);
      bus.done_i = 1'b1;
    end
    for (int i = 0; i < LEN; i++) begin
      exp_idx.push_back(i);
      exp_val.push_back(ref_bins[i]);
    end
    bus.progress_done_i = 1'b1;
    @(posedge clk);
    #1;
    bus.progress_done_i = 1'b0;
    bus.done_i          = 1'b0;
    chk("hist_valid_after_progress", int'(bus.hist_valid_o), 1);
    chk("pix_cnt", int'(bus.pix_cnt_o), ref_pix);
    frames_target++;
  endtask

  task automatic wait_frame();
    for (int c = 0; c < 3000; c++) begin
      if (frames_done >= frames_target) break;
      @(posedge clk);
      #1;
    end
    if (frames_done < frames_target) chk("frame_timeout", frames_done, frames_target);
    @(posedge clk);
    #1;
    model_clear();
  endtask

  initial begin
    bit found;
    bus.ni_i            = 4'd0;
    bus.rd_i            = 4'd0;
    bus.done_i          = 1'b0;
    bus.progress_done_i = 1'b0;
    frames_target       = 0;
    model_clear();

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    idle();
    chk("reset_hist_valid", int'(bus.hist_valid_o), 0);
    chk("reset_frame_done", int'(bus.frame_done_o), 0);
    chk("reset_err", int'(bus.err_o), 0);
    chk("reset_pix_cnt", int'(bus.pix_cnt_o), 0);
    chk("reset_bin_idx", int'(bus.bin_idx_o), 0);
    chk("reset_hist", int'(bus.hist_o), 0);

    // Frame 1: full frame into bin (3,7), always ready
    rmode = 0;
    for (int i = 0; i < 900; i++) sample(3, 7, 1);
    end_frame(0, 0, 0);
    wait_frame();
    chk("err_frame1", int'(bus.err_o), 0);

    // Frame 2: diagonal, 1,0,0 backpressure
    rmode = 1;
    for (int k = 0; k < BINS; k++)
      for (int j = 0; j < 5; j++) sample(k, k, 1);
    end_frame(0, 0, 0);
    wait_frame();

    // Random frame with gaps and random ready
    rmode = 2;
    for (int i = 0; i < 250; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else sample(int'($urandom_range(0, BINS - 1)), int'($urandom_range(0, BINS - 1)), 1);
    end
    end_frame(0, 0, 0);
    wait_frame();
    chk("err_random", int'(bus.err_o), 0);

    // Saturation of bin 0 and of the pixel counter
    rmode = 0;
    for (int i = 0; i < MAXC + 7; i++) sample(0, 0, 1);
    end_frame(0, 0, 0);
    wait_frame();
    chk("err_saturation", int'(bus.err_o), 0);

    // Coincident sample with progress, then a stray sample during readout
    rmode = 2;
    for (int i = 0; i < 12; i++)
      sample(int'($urandom_range(0, BINS - 1)), int'($urandom_range(0, BINS - 1)), 1);
    end_frame(1, 1, 1);
    sample(4, 4, 0);
    chk("err_after_stray_readout", int'(bus.err_o), 1);
    wait_frame();

    // Reset in the middle of readout
    rmode = 0;
    for (int i = 0; i < 20; i++)
      sample(int'($urandom_range(0, BINS - 1)), int'($urandom_range(0, BINS - 1)), 1);
    end_frame(0, 0, 0);
    frames_target--;
    found = 0;
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      if (bus.hist_valid_o && bus.bin_idx_o == 8'd40) begin
        found = 1;
        break;
      end
    end
    chk("reached_index_40", int'(found), 1);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_hist_valid", int'(bus.hist_valid_o), 0);
    chk("midreset_err", int'(bus.err_o), 0);
    chk("midreset_pix_cnt", int'(bus.pix_cnt_o), 0);
    chk("midreset_bin_idx", int'(bus.bin_idx_o), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    model_clear();
    end_frame(0, 0, 0);
    wait_frame();

    // Out-of-range codes are flagged and not binned
    sample(10, 2, 0);
    chk("err_after_bad_code", int'(bus.err_o), 1);
    sample(2, 15, 0);
    sample(5, 5, 1);
    end_frame(0, 0, 0);
    wait_frame();
    chk("err_sticky", int'(bus.err_o), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
